// File: rtl/gpr_file_if.sv
// Register-file port bundle: two writeback ports, two read ports, reserve strobe, busy status.
// The master modport is the pipeline side (decode + writeback); the slave modport is the register file.
interface gpr_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              w0_enable;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;
  logic              w1_enable;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              rsv_enable;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic              any_busy;

  modport master (
    output w0_enable, w0_addr, w0_data,
    output w1_enable, w1_addr, w1_data,
    output r_addr_a, r_addr_b, rsv_enable, rsv_addr,
    input  r_data_a, r_data_b, busy_a, busy_b, any_busy
  );

  modport slave (
    input  w0_enable, w0_addr, w0_data,
    input  w1_enable, w1_addr, w1_data,
    input  r_addr_a, r_addr_b, rsv_enable, rsv_addr,
    output r_data_a, r_data_b, busy_a, busy_b, any_busy
  );
endinterface

// File: rtl/gpr_file.sv
// GPR file with dual write ports (w0 priority) and busy scoreboard; GPR_BYPASS_EN adds same-cycle forwarding.
// Latency: reads combinational, write/reserve visible next cycle (zero cycles on reads with GPR_BYPASS_EN).
// Backpressure: none; writes always accepted, upstream stalls on busy_a/busy_b.
module gpr_file #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 9,
  parameter int ADDR_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  gpr_file_if.slave  bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [NUM_REGS-1:0] w0_hit;
  logic [NUM_REGS-1:0] w1_hit;
  logic [NUM_REGS-1:0] rsv_hit;

  logic [DATA_W-1:0]   view_data [NUM_REGS];
  logic [NUM_REGS-1:0] view_busy;

  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;
  logic                bsy_a;
  logic                bsy_b;

  // Out-of-range addresses never match an entry, so they drop out of writes, reserves and reads.
  always_comb begin
    w0_hit  = '0;
    w1_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w0_hit[i]  = bus.w0_enable  && (bus.w0_addr  == ADDR_W'(i));
      w1_hit[i]  = bus.w1_enable  && (bus.w1_addr  == ADDR_W'(i));
      rsv_hit[i] = bus.rsv_enable && (bus.rsv_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w1_hit[i]) regs_d[i] = bus.w1_data;
      if (w0_hit[i]) begin
        regs_d[i] = bus.w0_data;
        busy_d[i] = 1'b0;
      end
      // A fresh reserve beats a same-cycle clear: a new producer has issued.
      if (rsv_hit[i]) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    view_data = regs_q;
    view_busy = busy_q;
`ifdef GPR_BYPASS_EN
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w1_hit[i]) view_data[i] = bus.w1_data;
      if (w0_hit[i]) begin
        view_data[i] = bus.w0_data;
        if (!rsv_hit[i]) view_busy[i] = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    rd_a  = '0;
    rd_b  = '0;
    bsy_a = 1'b0;
    bsy_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.r_addr_a == ADDR_W'(i)) begin
        rd_a  = view_data[i];
        bsy_a = view_busy[i];
      end
      if (bus.r_addr_b == ADDR_W'(i)) begin
        rd_b  = view_data[i];
        bsy_b = view_busy[i];
      end
    end
  end

  assign bus.r_data_a = rd_a;
  assign bus.r_data_b = rd_b;
  assign bus.busy_a   = bsy_a;
  assign bus.busy_b   = bsy_b;
  assign bus.any_busy = |busy_q;

endmodule
